// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit MIPS-subset ALU.
// A single operation is in flight at a time; results return with the owner's id.
module alu_arbiter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [5:0]       req0_opcode,
    input  logic [5:0]       req0_func,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [5:0]       req1_opcode,
    input  logic [5:0]       req1_func,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_zero,
    output logic [CNT_W-1:0] ops_done
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        RESP
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD = 3'd0,
        ALU_SUB = 3'd1,
        ALU_AND = 3'd2,
        ALU_OR  = 3'd3,
        ALU_NOR = 3'd4,
        ALU_SLT = 3'd5
    } alu_ctl_t;

    state_t             state;
    state_t             state_nxt;
    logic               prio;
    logic               gnt0;
    logic               gnt1;
    logic               cap_id;
    logic [5:0]         cap_op;
    logic [5:0]         cap_func;
    logic [WIDTH-1:0]   cap_a;
    logic [WIDTH-1:0]   cap_b;
    alu_ctl_t           alu_ctl;
    logic [WIDTH-1:0]   alu_y;

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;

    // Grants exist only in IDLE and never while reset is held.
    always_comb begin
        state_nxt = state;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        unique case (state)
            IDLE: begin
                if (!rst) begin
                    gnt0 = req0_valid && (!req1_valid || !prio);
                    gnt1 = req1_valid && (!req0_valid || prio);
                end
                if (gnt0 || gnt1) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        alu_ctl = ALU_ADD;
        case (cap_op)
            6'h00: begin
                case (cap_func)
                    6'h20:   alu_ctl = ALU_ADD;
                    6'h22:   alu_ctl = ALU_SUB;
                    6'h24:   alu_ctl = ALU_AND;
                    6'h25:   alu_ctl = ALU_OR;
                    6'h27:   alu_ctl = ALU_NOR;
                    6'h2A:   alu_ctl = ALU_SLT;
                    default: alu_ctl = ALU_ADD;
                endcase
            end
            6'h04:   alu_ctl = ALU_SUB;
            default: alu_ctl = ALU_ADD;
        endcase
    end

    // slt compares unsigned operands
    always_comb begin
        alu_y = '0;
        case (alu_ctl)
            ALU_ADD: alu_y = cap_a + cap_b;
            ALU_SUB: alu_y = cap_a - cap_b;
            ALU_AND: alu_y = cap_a & cap_b;
            ALU_OR:  alu_y = cap_a | cap_b;
            ALU_NOR: alu_y = ~(cap_a | cap_b);
            ALU_SLT: alu_y = {{(WIDTH-1){1'b0}}, (cap_a < cap_b)};
            default: alu_y = cap_a + cap_b;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prio       <= 1'b0;
            cap_id     <= 1'b0;
            cap_op     <= '0;
            cap_func   <= '0;
            cap_a      <= '0;
            cap_b      <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_zero   <= 1'b0;
            ops_done   <= '0;
        end else begin
            if (gnt0) begin
                cap_id   <= 1'b0;
                cap_op   <= req0_opcode;
                cap_func <= req0_func;
                cap_a    <= req0_a;
                cap_b    <= req0_b;
            end else if (gnt1) begin
                cap_id   <= 1'b1;
                cap_op   <= req1_opcode;
                cap_func <= req1_func;
                cap_a    <= req1_a;
                cap_b    <= req1_b;
            end
            if (state == EXEC) begin
                rsp_valid  <= 1'b1;
                rsp_id     <= cap_id;
                rsp_result <= alu_y;
                rsp_zero   <= (alu_y == '0);
            end
            if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
                prio      <= ~rsp_id;
                ops_done  <= ops_done + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed self-checking bench for alu_arbiter.
// Each task drives one scenario and compares against hand-computed values.
module tb_alu_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req0_valid = 1'b0;
    logic        req0_ready;
    logic [5:0]  req0_opcode = '0;
    logic [5:0]  req0_func = '0;
    logic [31:0] req0_a = '0;
    logic [31:0] req0_b = '0;
    logic        req1_valid = 1'b0;
    logic        req1_ready;
    logic [5:0]  req1_opcode = '0;
    logic [5:0]  req1_func = '0;
    logic [31:0] req1_a = '0;
    logic [31:0] req1_b = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_zero;
    logic [15:0] ops_done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          r;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] y;
    } vec_t;

    vec_t vecs [14];

    alu_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
        .clk(clk),
        .rst(rst),
        .req0_valid(req0_valid),
        .req0_ready(req0_ready),
        .req0_opcode(req0_opcode),
        .req0_func(req0_func),
        .req0_a(req0_a),
        .req0_b(req0_b),
        .req1_valid(req1_valid),
        .req1_ready(req1_ready),
        .req1_opcode(req1_opcode),
        .req1_func(req1_func),
        .req1_a(req1_a),
        .req1_b(req1_b),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id(rsp_id),
        .rsp_result(rsp_result),
        .rsp_zero(rsp_zero),
        .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    task automatic set_req(input int r, input logic v, input logic [5:0] op,
                           input logic [5:0] fn, input logic [31:0] a,
                           input logic [31:0] b);
        if (r == 0) begin
            req0_valid = v; req0_opcode = op; req0_func = fn;
            req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_opcode = op; req1_func = fn;
            req1_a = a; req1_b = b;
        end
    endtask

    // Issues one request, scrambles operands after the handshake and
    // collects the response; ok=0 means a bound expired.
    task automatic run_op(input int r, input logic [5:0] op,
                          input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, output logic ok,
                          output logic [31:0] res, output logic id,
                          output logic z, output int lat);
        logic got;
        ok = 1'b0; res = '0; id = 1'b0; z = 1'b0; lat = 0; got = 1'b0;
        @(negedge clk);
        set_req(r, 1'b1, op, fn, a, b);
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if ((r == 0 && req0_ready) || (r == 1 && req1_ready)) got = 1'b1;
            else @(negedge clk);
        end
        if (!got) begin
            set_req(r, 1'b0, 6'h00, 6'h00, '0, '0);
        end else begin
            @(posedge clk);
            #1 set_req(r, 1'b0, 6'h3f, 6'h3f, 32'hdeadbeef, 32'hcafef00d);
            for (int i = 1; i <= 8; i++) begin
                @(negedge clk);
                if (rsp_valid) begin
                    lat = i;
                    break;
                end
            end
            if (lat != 0) begin
                res = rsp_result; id = rsp_id; z = rsp_zero; ok = 1'b1;
                rsp_ready = 1'b1;
                @(posedge clk);
                #1 rsp_ready = 1'b0;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        set_req(0, 1'b0, '0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0, '0);
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #1;
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b%b expected 00", req0_ready, req1_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp: valid=%b id=%b zero=%b expected 0 0 0",
                     rsp_valid, rsp_id, rsp_zero);
        end
        checks++;
        if (rsp_result !== 32'h0 || ops_done !== 16'h0) begin
            errors++;
            $display("FAIL reset_regs: result=%h ops=%0d expected 0 0",
                     rsp_result, ops_done);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_basic_add();
        logic ok, id, z;
        logic [31:0] res;
        int lat;
        run_op(0, 6'h00, 6'h20, 32'h2222, 32'h1111, ok, res, id, z, lat);
        checks++;
        if (ok !== 1'b1 || lat != 2) begin
            errors++;
            $display("FAIL add_latency: ok=%b lat=%0d expected ok=1 lat=2", ok, lat);
        end
        checks++;
        if (res !== 32'h3333 || id !== 1'b0 || z !== 1'b0) begin
            errors++;
            $display("FAIL add_result: res=%h id=%b z=%b expected 3333 0 0", res, id, z);
        end
        checks++;
        if (ops_done !== 16'd1) begin
            errors++;
            $display("FAIL add_ops: got %0d expected 1", ops_done);
        end
    endtask

    task automatic test_alu_ops();
        logic ok, id, z;
        logic [31:0] res;
        int lat;
        vecs[0]  = '{1, 6'h00, 6'h24, 32'h2222, 32'h1111, 32'h0000_0000};
        vecs[1]  = '{1, 6'h23, 6'h00, 32'h2222, 32'h1111, 32'h0000_3333};
        vecs[2]  = '{0, 6'h04, 6'h00, 32'h5555, 32'h5555, 32'h0000_0000};
        vecs[3]  = '{0, 6'h00, 6'h2A, 32'h1111, 32'h2222, 32'h0000_0001};
        vecs[4]  = '{0, 6'h00, 6'h2A, 32'h2222, 32'h1111, 32'h0000_0000};
        vecs[5]  = '{1, 6'h00, 6'h22, 32'h2222, 32'h1111, 32'h0000_1111};
        vecs[6]  = '{1, 6'h00, 6'h25, 32'h2222, 32'h1111, 32'h0000_3333};
        vecs[7]  = '{0, 6'h00, 6'h27, 32'h2222, 32'h1111, 32'hFFFF_CCCC};
        vecs[8]  = '{1, 6'h00, 6'h22, 32'h0001, 32'h0002, 32'hFFFF_FFFF};
        vecs[9]  = '{0, 6'h00, 6'h20, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000};
        vecs[10] = '{1, 6'h00, 6'h2A, 32'hFFFF_FFFF, 32'h1, 32'h0000_0000};
        vecs[11] = '{0, 6'h00, 6'h21, 32'h2222, 32'h1111, 32'h0000_3333};
        vecs[12] = '{1, 6'h08, 6'h22, 32'h2222, 32'h1111, 32'h0000_3333};
        vecs[13] = '{0, 6'h2B, 6'h00, 32'h0010, 32'h0020, 32'h0000_0030};
        for (int i = 0; i < 14; i++) begin
            run_op(vecs[i].r, vecs[i].op, vecs[i].fn, vecs[i].a, vecs[i].b,
                   ok, res, id, z, lat);
            checks++;
            if (ok !== 1'b1 || res !== vecs[i].y || id !== vecs[i].r[0] ||
                z !== (vecs[i].y == 32'h0)) begin
                errors++;
                $display("FAIL alu_vec%0d: ok=%b res=%h id=%b z=%b expected res=%h id=%0d",
                         i, ok, res, id, z, vecs[i].y, vecs[i].r);
            end
        end
        checks++;
        if (ops_done !== 16'd15) begin
            errors++;
            $display("FAIL alu_ops: got %0d expected 15", ops_done);
        end
    endtask

    task automatic test_back_to_back();
        int gnt [4];
        int ids [4];
        logic [31:0] res [4];
        int ng = 0;
        int nr = 0;
        int cnt0 = 0;
        int cnt1 = 0;
        int both = 0;
        do_reset();
        set_req(0, 1'b1, 6'h00, 6'h20, 32'h1, 32'h0);
        set_req(1, 1'b1, 6'h00, 6'h20, 32'h2, 32'h0);
        rsp_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (req0_ready && req1_ready) both++;
            if (req0_ready) begin
                cnt0++;
                if (ng < 4) gnt[ng] = 0;
                ng++;
            end
            if (req1_ready) begin
                cnt1++;
                if (ng < 4) gnt[ng] = 1;
                ng++;
            end
            if (rsp_valid) begin
                ids[nr] = int'(rsp_id);
                res[nr] = rsp_result;
                nr++;
            end
            if (nr == 4) break;
            @(negedge clk);
        end
        set_req(0, 1'b0, '0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0, '0);
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        checks++;
        if (nr != 4 || ng != 4 || both != 0 || cnt0 != 2 || cnt1 != 2) begin
            errors++;
            $display("FAIL b2b_counts: rsp=%0d gnt=%0d both=%0d r0=%0d r1=%0d expected 4 4 0 2 2",
                     nr, ng, both, cnt0, cnt1);
        end else begin
            checks++;
            if (gnt[0] != 0 || gnt[1] != 1 || gnt[2] != 0 || gnt[3] != 1) begin
                errors++;
                $display("FAIL b2b_order: got %0d%0d%0d%0d expected 0101",
                         gnt[0], gnt[1], gnt[2], gnt[3]);
            end
            checks++;
            if (ids[0] != 0 || ids[1] != 1 || ids[2] != 0 || ids[3] != 1 ||
                res[0] !== 32'h1 || res[1] !== 32'h2 ||
                res[2] !== 32'h1 || res[3] !== 32'h2) begin
                errors++;
                $display("FAIL b2b_rsp: ids=%0d%0d%0d%0d res=%h %h %h %h expected 0101 1 2 1 2",
                         ids[0], ids[1], ids[2], ids[3], res[0], res[1], res[2], res[3]);
            end
        end
        checks++;
        if (ops_done !== 16'd4) begin
            errors++;
            $display("FAIL b2b_ops: got %0d expected 4", ops_done);
        end
    endtask

    task automatic test_rsp_stall();
        logic got = 1'b0;
        logic seen = 1'b0;
        @(negedge clk);
        set_req(0, 1'b1, 6'h00, 6'h20, 32'h100, 32'h23);
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (req0_ready) got = 1'b1;
            else @(negedge clk);
        end
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 6'h00, 6'h20, 32'h7, 32'h0);
        set_req(1, 1'b1, 6'h00, 6'h20, 32'h9, 32'h0);
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (!got || !seen) begin
            errors++;
            $display("FAIL stall_start: grant=%b rsp=%b expected 1 1", got, seen);
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            checks++;
            if (rsp_valid !== 1'b1 || rsp_result !== 32'h123 || rsp_id !== 1'b0 ||
                req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold%0d: v=%b res=%h id=%b rdy=%b%b expected 1 123 0 00",
                         k, rsp_valid, rsp_result, rsp_id, req0_ready, req1_ready);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        checks++;
        if (ops_done !== 16'd5 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_release: ops=%0d v=%b expected 5 0", ops_done, rsp_valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL stall_next_grant: rdy0=%b rdy1=%b expected 0 1", req0_ready, req1_ready);
        end
        @(posedge clk);
        #1;
        set_req(0, 1'b0, '0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0, '0);
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (rsp_valid) seen = 1'b1;
        end
        checks++;
        if (!seen || rsp_result !== 32'h9 || rsp_id !== 1'b1) begin
            errors++;
            $display("FAIL stall_second: seen=%b res=%h id=%b expected 1 9 1", seen, rsp_result, rsp_id);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid(input int phase);
        logic ok, id, z, got;
        logic [31:0] res;
        int lat;
        int late = 0;
        got = 1'b0;
        run_op(0, 6'h00, 6'h20, 32'h1, 32'h1, ok, res, id, z, lat);
        @(negedge clk);
        set_req(1, 1'b1, 6'h00, 6'h20, 32'h5, 32'h5);
        for (int i = 0; i < 10 && !got; i++) begin
            #1;
            if (req1_ready) got = 1'b1;
            else @(negedge clk);
        end
        @(posedge clk);
        #1 set_req(1, 1'b0, '0, '0, '0, '0);
        if (phase == 1) begin
            @(posedge clk);
            #1;
        end
        checks++;
        if (!got || !ok || rsp_valid !== (phase == 1)) begin
            errors++;
            $display("FAIL rstmid%0d_setup: grant=%b ok=%b v=%b expected 1 1 %0d",
                     phase, got, ok, rsp_valid, phase);
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || ops_done !== 16'd0) begin
            errors++;
            $display("FAIL rstmid%0d_clear: v=%b ops=%0d expected 0 0", phase, rsp_valid, ops_done);
        end
        repeat (3) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) late++;
        end
        checks++;
        if (late != 0) begin
            errors++;
            $display("FAIL rstmid%0d_noresp: got %0d valid cycles expected 0", phase, late);
        end
        set_req(0, 1'b1, 6'h00, 6'h20, 32'h1, 32'h1);
        set_req(1, 1'b1, 6'h00, 6'h20, 32'h1, 32'h1);
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL rstmid%0d_prio: rdy0=%b rdy1=%b expected 1 0", phase, req0_ready, req1_ready);
        end
        set_req(0, 1'b0, '0, '0, '0, '0);
        set_req(1, 1'b0, '0, '0, '0, '0);
    endtask

    initial begin
        test_reset();
        test_basic_add();
        test_alu_ops();
        test_back_to_back();
        test_rsp_stall();
        test_reset_mid(0);
        test_reset_mid(1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
